// File: rtl/csa_sub24_pipe_pkg.sv
// Shared ALU constants and types for the registered 24-bit subtract path.
package csa_sub24_pipe_pkg;

  localparam int ALU_OPW   = 24;
  localparam int ALU_RESW  = ALU_OPW + 1;
  localparam int ALU_SPLIT = 12;

  typedef logic signed [ALU_RESW-1:0] alu_res_t;

  // True when every bit of a difference is zero
  function automatic logic res_is_zero(input alu_res_t r);
    return (r == '0);
  endfunction

endpackage

// File: rtl/csa_sub24_pipe_if.sv
// Operand/result handshake bundle for the pipelined subtractor.
interface csa_sub24_pipe_if
  import csa_sub24_pipe_pkg::*;
  #(parameter int WIDTH = ALU_OPW) ();

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] op1;
  logic signed [WIDTH-1:0] op2;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH:0]   result;
  logic                    zero;
  logic                    neg;

  // Producer of operands and consumer of results
  modport master (
    output in_valid, op1, op2, out_ready,
    input  in_ready, out_valid, result, zero, neg
  );

  // The subtractor itself
  modport slave (
    input  in_valid, op1, op2, out_ready,
    output in_ready, out_valid, result, zero, neg
  );

endinterface

// File: rtl/csa_sub24_pipe_csel.sv
// Carry-select segment: sums a+b for both possible carry-ins.
module csel_seg #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum0,
  output logic         cout0,
  output logic [W-1:0] sum1,
  output logic         cout1
);

  // Speculative sums for carry-in 0 and carry-in 1
  always_comb begin
    {cout0, sum0} = {1'b0, a} + {1'b0, b};
    {cout1, sum1} = {1'b0, a} + {1'b0, b} + (W+1)'(1);
  end

endmodule

// File: rtl/csa_sub24_pipe.sv
// Two-stage carry-select subtractor: result = op1 - op2, exact WIDTH+1 bits.
// Stage 1 registers the low segment (with the +1 of two's complement negation)
// and both speculative high sums; stage 2 selects the high half by c_lo.
module csa_sub24_pipe
  import csa_sub24_pipe_pkg::*;
#(
  parameter int WIDTH = ALU_OPW,
  parameter int SPLIT = ALU_SPLIT
) (
  input  logic                clk,
  input  logic                rst,
  csa_sub24_pipe_if.slave     bus
);

  localparam int HI_W = WIDTH + 1 - SPLIT;

  logic signed [WIDTH:0] a_p0;
  logic signed [WIDTH:0] b_p0;
  logic [SPLIT-1:0]      lo_sum_p0;
  logic                  lo_c_p0;
  logic [HI_W-1:0]       hi0_p0;
  logic [HI_W-1:0]       hi1_p0;
  logic [SPLIT-1:0]      lo_sum0_unused;
  logic                  lo_cout0_unused;
  logic                  hi_cout0_unused;
  logic                  hi_cout1_unused;

  logic                  s1_adv;
  logic                  s2_adv;
  logic                  ld_p1;
  logic                  ld_p2;
  logic signed [WIDTH:0] sel_p1;

  logic                  vld_p1_q, vld_p1_d;
  logic [SPLIT-1:0]      lo_p1_q, lo_p1_d;
  logic                  clo_p1_q, clo_p1_d;
  logic [HI_W-1:0]       hi0_p1_q, hi0_p1_d;
  logic [HI_W-1:0]       hi1_p1_q, hi1_p1_d;

  logic                  vld_p2_q, vld_p2_d;
  logic signed [WIDTH:0] result_p2_q, result_p2_d;
  logic                  zero_p2_q, zero_p2_d;
  logic                  neg_p2_q, neg_p2_d;

  // ---- stage 0: operand conditioning, op1 + ~op2 + 1 ----
  assign a_p0 = {bus.op1[WIDTH-1], bus.op1};
  assign b_p0 = ~{bus.op2[WIDTH-1], bus.op2};

  // Low segment always carries in the +1, so only its cin=1 outputs matter
  csel_seg #(.W(SPLIT)) u_lo (
    .a     (a_p0[SPLIT-1:0]),
    .b     (b_p0[SPLIT-1:0]),
    .sum0  (lo_sum0_unused),
    .cout0 (lo_cout0_unused),
    .sum1  (lo_sum_p0),
    .cout1 (lo_c_p0)
  );

  // High segment resolves both carry-ins; its carry-out is the discarded bit 25
  csel_seg #(.W(HI_W)) u_hi (
    .a     (a_p0[WIDTH:SPLIT]),
    .b     (b_p0[WIDTH:SPLIT]),
    .sum0  (hi0_p0),
    .cout0 (hi_cout0_unused),
    .sum1  (hi1_p0),
    .cout1 (hi_cout1_unused)
  );

  // Handshake advance terms and next-state for both stages
  always_comb begin
    s2_adv   = !vld_p2_q || bus.out_ready;
    s1_adv   = !vld_p1_q || s2_adv;
    ld_p1    = s1_adv && bus.in_valid;
    ld_p2    = s2_adv && vld_p1_q;

    vld_p1_d = s1_adv ? bus.in_valid : vld_p1_q;
    lo_p1_d  = ld_p1 ? lo_sum_p0 : lo_p1_q;
    clo_p1_d = ld_p1 ? lo_c_p0   : clo_p1_q;
    hi0_p1_d = ld_p1 ? hi0_p0    : hi0_p1_q;
    hi1_p1_d = ld_p1 ? hi1_p0    : hi1_p1_q;

    // ---- stage 1 -> stage 2: carry select ----
    sel_p1      = {(clo_p1_q ? hi1_p1_q : hi0_p1_q), lo_p1_q};
    vld_p2_d    = s2_adv ? vld_p1_q : vld_p2_q;
    result_p2_d = ld_p2 ? sel_p1             : result_p2_q;
    zero_p2_d   = ld_p2 ? res_is_zero(sel_p1) : zero_p2_q;
    neg_p2_d    = ld_p2 ? sel_p1[WIDTH]       : neg_p2_q;
  end

  // Control state and visible outputs; reset clears pipeline occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      result_p2_q <= '0;
      zero_p2_q   <= 1'b0;
      neg_p2_q    <= 1'b0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      result_p2_q <= result_p2_d;
      zero_p2_q   <= zero_p2_d;
      neg_p2_q    <= neg_p2_d;
    end
  end

  // ---- stage 1 data registers (contents meaningless while vld_p1_q=0) ----
  always_ff @(posedge clk) begin
    lo_p1_q  <= lo_p1_d;
    clo_p1_q <= clo_p1_d;
    hi0_p1_q <= hi0_p1_d;
    hi1_p1_q <= hi1_p1_d;
  end

  // ---- stage 2: outputs ----
  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = vld_p2_q;
  assign bus.result    = result_p2_q;
  assign bus.zero      = zero_p2_q;
  assign bus.neg       = neg_p2_q;

endmodule

// File: tb/tb_csa_sub24_pipe.sv
// Self-checking bench for csa_sub24_pipe against a plain-arithmetic model.
module tb_csa_sub24_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  csa_sub24_pipe_if bus ();

  csa_sub24_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: exact signed difference, as a 25-bit pattern
  function automatic logic [24:0] ref_sub(input logic [23:0] x, input logic [23:0] y);
    logic signed [24:0] sx, sy, d;
    sx = $signed({x[23], x});
    sy = $signed({y[23], y});
    d  = sx - sy;
    return d;
  endfunction

  // Drive one cycle of inputs, sample outputs before the edge, then advance
  task automatic clk_cycle(input logic iv, input logic [23:0] o1, input logic [23:0] o2,
                           input logic ordy, output logic rdy, output logic vld,
                           output logic acc, output logic emit, output logic [24:0] res,
                           output logic z, output logic n);
    bus.in_valid  = iv;
    bus.op1       = o1;
    bus.op2       = o2;
    bus.out_ready = ordy;
    #1;
    rdy  = bus.in_ready;
    vld  = bus.out_valid;
    res  = bus.result;
    z    = bus.zero;
    n    = bus.neg;
    acc  = iv && rdy;
    emit = vld && ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.op1 = '0; bus.op2 = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.result !== 25'h0) begin errors++; $display("FAIL reset_result got=%h want=0", bus.result); end
    checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL reset_zero got=%b want=0", bus.zero); end
    checks++; if (bus.neg !== 1'b0) begin errors++; $display("FAIL reset_neg got=%b want=0", bus.neg); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_vectors();
    logic [23:0] va [7] = '{24'h000005, 24'h000000, 24'h123456, 24'h7FFFFF, 24'h800000, 24'h001000, 24'h000FFF};
    logic [23:0] vb [7] = '{24'h000003, 24'h000001, 24'h123456, 24'h800000, 24'h7FFFFF, 24'h000001, 24'hFFFFFF};
    logic [24:0] vr [7] = '{25'h0000002, 25'h1FFFFFF, 25'h0000000, 25'h0FFFFFF, 25'h1000001, 25'h0000FFF, 25'h0001000};
    logic        vz [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        vn [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic rdy, vld, acc, emit, z, n;
    logic [24:0] res;
    for (int i = 0; i < 7; i++) begin
      clk_cycle(1'b1, va[i], vb[i], 1'b1, rdy, vld, acc, emit, res, z, n);
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL vec%0d_accept got=%b want=1", i, acc); end
      clk_cycle(1'b0, 24'h0, 24'h0, 1'b1, rdy, vld, acc, emit, res, z, n);
      checks++; if (vld !== 1'b0) begin errors++; $display("FAIL vec%0d_early_valid got=%b want=0", i, vld); end
      clk_cycle(1'b0, 24'h0, 24'h0, 1'b1, rdy, vld, acc, emit, res, z, n);
      checks++; if (vld !== 1'b1) begin errors++; $display("FAIL vec%0d_latency got=%b want=1", i, vld); end
      checks++; if (res !== vr[i] || z !== vz[i] || n !== vn[i]) begin
        errors++;
        $display("FAIL vec%0d_value got=%h z=%b n=%b want=%h z=%b n=%b", i, res, z, n, vr[i], vz[i], vn[i]);
      end
    end
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL vec_drain got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    logic [23:0] pa [4];
    logic [23:0] pb [4];
    logic [24:0] q [$];
    logic rdy, vld, acc, emit, z, n;
    logic [24:0] res;
    int sent = 0;
    int rcvd = 0;
    for (int i = 0; i < 4; i++) begin pa[i] = 24'($urandom); pb[i] = 24'($urandom); end
    for (int cyc = 0; cyc < 40 && rcvd < 4; cyc++) begin
      clk_cycle(sent < 4, pa[sent % 4], pb[sent % 4], cyc >= 4, rdy, vld, acc, emit, res, z, n);
      if (cyc < 4) begin
        checks++; if (rdy !== (cyc < 2)) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b want=%b", cyc, rdy, cyc < 2); end
      end
      if (cyc == 2 || cyc == 3) begin
        checks++; if (vld !== 1'b1 || res !== ref_sub(pa[0], pb[0])) begin
          errors++; $display("FAIL bp_hold cyc=%0d got=%h v=%b want=%h v=1", cyc, res, vld, ref_sub(pa[0], pb[0]));
        end
      end
      if (emit) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL bp_extra got=%h want=none", res); end
        else begin
          if (res !== q[0]) begin errors++; $display("FAIL bp_order idx=%0d got=%h want=%h", rcvd, res, q[0]); end
          void'(q.pop_front());
        end
        rcvd++;
      end
      if (acc) begin q.push_back(ref_sub(pa[sent], pb[sent])); sent++; end
    end
    checks++; if (rcvd != 4) begin errors++; $display("FAIL bp_count got=%0d want=4", rcvd); end
  endtask

  task automatic test_random();
    logic [24:0] q [$];
    logic rdy, vld, acc, emit, z, n, iv, ordy;
    logic [24:0] res, prev_res;
    logic [23:0] o1, o2;
    logic prev_stall = 1'b0;
    int sent = 0;
    int rcvd = 0;
    int cyc = 0;
    prev_res = '0;
    while (rcvd < 1000 && cyc < 8000) begin
      iv   = (sent < 1000) && ($urandom_range(0, 99) < 70);
      ordy = (sent >= 1000) || ($urandom_range(0, 99) < 60);
      o1   = 24'($urandom);
      o2   = 24'($urandom);
      if ($urandom_range(0, 15) == 0) o2 = o1;
      clk_cycle(iv, o1, o2, ordy, rdy, vld, acc, emit, res, z, n);
      checks++; if (rdy !== !(q.size() == 2 && !ordy)) begin
        errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", cyc, rdy, !(q.size() == 2 && !ordy));
      end
      if (prev_stall) begin
        checks++; if (vld !== 1'b1 || res !== prev_res) begin
          errors++; $display("FAIL rnd_stall_hold cyc=%0d got=%h want=%h", cyc, res, prev_res);
        end
      end
      if (emit) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL rnd_extra got=%h want=none", res); end
        else begin
          if (res !== q[0] || z !== (q[0] == 25'h0) || n !== q[0][24]) begin
            errors++; $display("FAIL rnd_value idx=%0d got=%h z=%b n=%b want=%h", rcvd, res, z, n, q[0]);
          end
          void'(q.pop_front());
        end
        rcvd++;
      end
      if (acc) begin q.push_back(ref_sub(o1, o2)); sent++; end
      prev_stall = vld && !ordy;
      prev_res   = res;
      cyc++;
    end
    checks++; if (rcvd != 1000 || q.size() != 0) begin
      errors++; $display("FAIL rnd_count got=%0d left=%0d want=1000 left=0", rcvd, q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic rdy, vld, acc, emit, z, n;
    logic [24:0] res;
    int seen = 0;
    clk_cycle(1'b1, 24'h111111, 24'h000001, 1'b0, rdy, vld, acc, emit, res, z, n);
    clk_cycle(1'b1, 24'h222222, 24'h000002, 1'b0, rdy, vld, acc, emit, res, z, n);
    checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL rm_full got v=%b r=%b want v=1 r=0", bus.out_valid, bus.in_ready);
    end
    rst = 1'b1;
    clk_cycle(1'b1, 24'h333333, 24'h000003, 1'b1, rdy, vld, acc, emit, res, z, n);
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got=%b want=1", bus.in_ready); end
    for (int i = 0; i < 6; i++) begin
      clk_cycle(1'b0, 24'h0, 24'h0, 1'b1, rdy, vld, acc, emit, res, z, n);
      if (vld) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rm_ghost got=%0d want=0", seen); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
